// File: rtl/fetch_stage_pkg.sv
// Purpose: shared fetch-stage state encodings and constants.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_REQ     = 2'd1,
        FS_DISCARD = 2'd2
    } fs_state_e;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PC_STEP = 4;

    // Value shown on the instruction output before anything has been fetched.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Purpose: small synchronous FIFO holding {pc, instr} entries between imem and decode.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle; flush wins over push/pop.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Entry storage; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: IF stage - owns the PC, issues one imem word request at a time, buffers {pc,instr} for decode.
// Latency: an ack is captured at its clock edge and appears on fs_o_ce the cycle after (1 word/cycle with a same-cycle ack).
// Backpressure: fs_i_stall holds the buffer head; no request is issued unless buffer entries plus outstanding fit.
// Optional: define FETCH_PERF_CNT_EN to add fs_o_fetch_cnt / fs_o_stall_cnt saturating counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                   PC_WIDTH  = 32,
    parameter int                   IWIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter int                   BUF_DEPTH = 2
) (
    input  logic                fs_clk,
    input  logic                fs_rst,
    input  logic                fs_i_ce,
    input  logic                fs_i_stall,
    input  logic                fs_i_change_pc,
    input  logic [PC_WIDTH-1:0] fs_i_target_pc,
    output logic                fs_o_imem_req,
    output logic [PC_WIDTH-1:0] fs_o_imem_addr,
    input  logic                fs_i_imem_ack,
    input  logic [IWIDTH-1:0]   fs_i_imem_data,
    output logic [IWIDTH-1:0]   fs_o_instr,
    output logic [PC_WIDTH-1:0] fs_o_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         fs_o_fetch_cnt,
    output logic [31:0]         fs_o_stall_cnt,
`endif
    output logic                fs_o_ce
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int ENT_W = PC_WIDTH + IWIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    fs_state_e           state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic                req_q;
    logic [PC_WIDTH-1:0] pc_inc;

    logic                buf_full;
    logic                buf_empty;
    logic [CNT_W-1:0]    buf_cnt;
    logic [ENT_W-1:0]    head_dat;
    logic                push_vld;
    logic                pop_vld;
    logic [CNT_W:0]      cnt_after;
    logic                space_after;

    logic [IWIDTH-1:0]   last_instr_q;
    logic [PC_WIDTH-1:0] last_pc_q;

    // In REQ the PC always equals the address on the bus, so the pushed pc is pc_q.
    assign pc_inc   = pc_q + PC_WIDTH'(PC_STEP);
    assign push_vld = (state_q == FS_REQ) && fs_i_imem_ack && !fs_i_change_pc;
    // Redirect beats pop: the flushed head is never counted as consumed.
    assign pop_vld  = !buf_empty && !fs_i_stall && !fs_i_change_pc;

    // Room check for keeping the request line up right after an ack.
    assign cnt_after   = {1'b0, buf_cnt} + (CNT_W+1)'(1) - (CNT_W+1)'(pop_vld);
    assign space_after = (cnt_after < {1'b0, DEPTH_C});

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENT_W)
    ) u_buf (
        .clk_i      (fs_clk),
        .rst_i      (fs_rst),
        .push_i     (push_vld),
        .push_dat_i ({pc_q, fs_i_imem_data}),
        .pop_i      (pop_vld),
        .flush_i    (fs_i_change_pc),
        .head_dat_o (head_dat),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .count_o    (buf_cnt)
    );

    // Request FSM: PC, registered request line and address, DISCARD tracking of a redirected request.
    always_ff @(posedge fs_clk) begin
        if (fs_rst) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (fs_i_change_pc) begin
                        // Buffer is being flushed, so there is room for the target.
                        pc_q <= fs_i_target_pc;
                        if (fs_i_ce) begin
                            state_q <= FS_REQ;
                            req_q   <= 1'b1;
                            addr_q  <= fs_i_target_pc;
                        end
                    end else if (fs_i_ce && !buf_full) begin
                        state_q <= FS_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                FS_REQ: begin
                    if (fs_i_change_pc) begin
                        pc_q <= fs_i_target_pc;
                        if (!fs_i_imem_ack) begin
                            // Keep req/addr stable; the late response will be dropped.
                            state_q <= FS_DISCARD;
                        end else if (fs_i_ce) begin
                            addr_q <= fs_i_target_pc;
                        end else begin
                            state_q <= FS_IDLE;
                            req_q   <= 1'b0;
                        end
                    end else if (fs_i_imem_ack) begin
                        pc_q <= pc_inc;
                        if (fs_i_ce && space_after) begin
                            addr_q <= pc_inc;
                        end else begin
                            state_q <= FS_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                FS_DISCARD: begin
                    if (fs_i_change_pc) begin
                        pc_q <= fs_i_target_pc;
                    end
                    if (fs_i_imem_ack) begin
                        if (fs_i_ce) begin
                            state_q <= FS_REQ;
                            addr_q  <= fs_i_change_pc ? fs_i_target_pc : pc_q;
                        end else begin
                            state_q <= FS_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= FS_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Remember the most recent head so the outputs hold their value once the buffer drains.
    always_ff @(posedge fs_clk) begin
        if (fs_rst) begin
            last_instr_q <= IWIDTH'(NOP_INSTR);
            last_pc_q    <= '0;
        end else if (!buf_empty) begin
            {last_pc_q, last_instr_q} <= head_dat;
        end
    end

    assign fs_o_imem_req  = req_q;
    assign fs_o_imem_addr = addr_q;
    assign fs_o_ce        = !buf_empty;
    assign {fs_o_pc, fs_o_instr} = buf_empty ? {last_pc_q, last_instr_q} : head_dat;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating counts of buffered instructions and of stalled valid cycles.
    always_ff @(posedge fs_clk) begin
        if (fs_rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push_vld && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!buf_empty && fs_i_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fs_o_fetch_cnt = fetch_cnt_q;
    assign fs_o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: self-checking bench for fetch_stage against a stream-level fetch model.
// Latency: imem responder acks after 1..3 cycles of a held request (1 = same cycle).
// Backpressure: stall and fetch-enable are driven both directed and random.
module tb_fetch_stage;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        stall;
    logic        chg;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] opc;
    logic        oce;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Stream model: next address expected to be kept, next pc expected at decode.
    logic [31:0] fetch_pc;
    logic [31:0] out_pc;
    int          occ;
    bit          discard;
    int          kept_total;
    int          stall_cyc;
    int          kept_since;
    // imem responder
    int          lat_cfg;
    int          resp_wait;
    int          resp_lat;
    bit          force_ack;

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_WIDTH  (32),
        .IWIDTH    (32),
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .fs_clk         (clk),
        .fs_rst         (rst),
        .fs_i_ce        (ce),
        .fs_i_stall     (stall),
        .fs_i_change_pc (chg),
        .fs_i_target_pc (tgt),
        .fs_o_imem_req  (req),
        .fs_o_imem_addr (addr),
        .fs_i_imem_ack  (ack),
        .fs_i_imem_data (rdata),
        .fs_o_instr     (instr),
        .fs_o_pc        (opc),
`ifdef FETCH_PERF_CNT_EN
        .fs_o_fetch_cnt (fetch_cnt),
        .fs_o_stall_cnt (stall_cnt),
`endif
        .fs_o_ce        (oce)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0043_0820;
        if (a == 32'h0000_0004) return 32'h0424_000A;
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: update the model from pre-edge values, step, check, then drive the imem response.
    task automatic tick();
        logic        p_oce, p_req, p_ack, p_chg, p_stall, p_ce, p_rst;
        logic [31:0] p_pc, p_instr, p_addr;
        p_oce = oce; p_req = req; p_ack = ack; p_chg = chg; p_stall = stall;
        p_ce = ce; p_rst = rst; p_pc = opc; p_instr = instr; p_addr = addr;

        if (p_rst) begin
            occ = 0; discard = 0; fetch_pc = RST_PC; out_pc = RST_PC;
            kept_total = 0; stall_cyc = 0;
        end else begin
            if (p_oce && p_stall) stall_cyc++;
            if (p_oce && !p_stall && !p_chg) begin
                check_eq("pop_pc", p_pc, out_pc);
                check_eq("pop_instr", p_instr, mem_word(out_pc));
                out_pc = out_pc + 32'd4;
                occ--;
            end
            if (p_req && p_ack && !p_chg) begin
                if (discard) begin
                    discard = 0;
                end else begin
                    check_eq("req_addr", p_addr, fetch_pc);
                    fetch_pc = fetch_pc + 32'd4;
                    occ++;
                    kept_total++;
                    kept_since++;
                end
            end
            if (p_chg) begin
                occ = 0;
                fetch_pc = tgt;
                out_pc = tgt;
                discard = p_req && !p_ack;
            end
        end

        @(posedge clk);
        #1;

        check_eq("ce_vs_occ", oce, (occ > 0));
        if (!p_rst) begin
            check_eq("room", ((occ + int'(req)) <= DEPTH), 1'b1);
            if (p_req && !p_ack) check_eq("req_hold", {req, addr}, {1'b1, p_addr});
            if (req && (!p_req || p_ack)) check_eq("new_req_ce", p_ce, 1'b1);
            if (p_oce && p_stall && !p_chg) begin
                check_eq("stall_pc", opc, p_pc);
                check_eq("stall_instr", instr, p_instr);
            end
            if (!p_oce && !oce) begin
                check_eq("empty_hold_pc", opc, p_pc);
                check_eq("empty_hold_instr", instr, p_instr);
            end
        end

        if (req) begin
            if (!p_req || p_ack || p_rst) begin
                resp_wait = 0;
                resp_lat  = (lat_cfg == 0) ? $urandom_range(1, 3) : lat_cfg;
            end
            resp_wait++;
            ack   = (resp_wait >= resp_lat);
            rdata = ack ? mem_word(addr) : $urandom();
        end else begin
            ack   = force_ack;
            rdata = $urandom();
        end
    endtask

    task automatic wait_oce(input string tag);
        for (int i = 0; i < 20 && !oce; i++) tick();
        check_eq(tag, oce, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req", req, 1'b0);
        check_eq("rst_addr", addr, RST_PC);
        check_eq("rst_ce", oce, 1'b0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", opc, 32'h0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; stall = 1'b0; chg = 1'b0; tgt = '0;
        ack = 1'b0; rdata = '0; force_ack = 1'b0; lat_cfg = 1;
        resp_wait = 0; resp_lat = 1; kept_since = 0;
        fetch_pc = RST_PC; out_pc = RST_PC; occ = 0; discard = 0;
        kept_total = 0; stall_cyc = 0;
        tick(); tick();
        check_reset_outputs();

        // Throughput with a same-cycle imem: pairs on consecutive cycles.
        rst = 1'b0; ce = 1'b1;
        wait_oce("first_valid");
        check_eq("first_pc", opc, 32'h0);
        check_eq("first_instr", instr, 32'h0043_0820);
        tick();
        check_eq("second_ce", oce, 1'b1);
        check_eq("second_pc", opc, 32'h4);
        check_eq("second_instr", instr, 32'h0424_000A);

        // Decode stall for 5 cycles: head frozen, buffer bounds the fetches.
        stall = 1'b1; kept_since = 0;
        repeat (5) tick();
        check_eq("stall_fetches", (kept_since <= DEPTH), 1'b1);
        stall = 1'b0;
        repeat (6) tick();

        // Redirect while a 3-cycle request for 0x8 is outstanding.
        rst = 1'b1; tick(); rst = 1'b0; lat_cfg = 3;
        for (int i = 0; i < 40 && !(req && addr == 32'h8 && !ack); i++) tick();
        check_eq("req8_seen", {req, addr, ack}, {1'b1, 32'h8, 1'b0});
        chg = 1'b1; tgt = 32'h40; tick(); chg = 1'b0;
        check_eq("redir_flush", oce, 1'b0);
        wait_oce("redir_valid");
        check_eq("redir_pc", opc, 32'h40);

        // Redirect coinciding with an ack.
        lat_cfg = 1;
        for (int i = 0; i < 20 && !(req && ack); i++) tick();
        check_eq("ack_seen", {req, ack}, 2'b11);
        chg = 1'b1; tgt = 32'h100; tick(); chg = 1'b0;
        check_eq("ackredir_flush", oce, 1'b0);
        check_eq("ackredir_req", {req, addr}, {1'b1, 32'h100});
        wait_oce("ackredir_valid");
        check_eq("ackredir_pc", opc, 32'h100);

        // PC wrap from the top of the address space.
        chg = 1'b1; tgt = 32'hFFFF_FFF8; tick(); chg = 1'b0;
        for (int i = 0; i < 20 && !(req && ack && addr == 32'hFFFF_FFFC); i++) tick();
        check_eq("top_seen", {req, ack, addr}, {2'b11, 32'hFFFF_FFFC});
        tick();
        check_eq("wrap_addr", addr, 32'h0);
        repeat (4) tick();

        // Reset while a request is outstanding; a late ack must be ignored.
        lat_cfg = 3;
        for (int i = 0; i < 20 && !(req && !ack); i++) tick();
        ce = 1'b0; rst = 1'b1; force_ack = 1'b1; tick();
        check_reset_outputs();
        rst = 1'b0; force_ack = 1'b0; tick();
        check_eq("late_ack_ce", oce, 1'b0);
        check_eq("late_ack_req", req, 1'b0);
        ce = 1'b1; lat_cfg = 1;
        wait_oce("restart_valid");
        check_eq("restart_pc", opc, RST_PC);

        // Randomized traffic against the stream model.
        lat_cfg = 0;
        for (int c = 0; c < 3000; c++) begin
            ce    = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 2) == 0);
            chg   = ($urandom_range(0, 24) == 0);
            tgt   = $urandom();
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF0;
            tick();
        end
        chg = 1'b0; stall = 1'b0;
        repeat (4) tick();

`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetch", fetch_cnt, kept_total);
        check_eq("perf_stall", stall_cnt, stall_cyc);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
